// File: rtl/rom_port_arbiter_if.sv
// Fetch and load request/response handshake bundle for rom_port_arbiter.
// The slave modport is the arbiter side; master is the requesting core side.
interface rom_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_req_ready;
  logic                  if_rsp_valid;
  logic [DATA_WIDTH-1:0] if_rsp_data;
  logic                  if_rsp_ready;

  logic                  ld_req_valid;
  logic [ADDR_WIDTH-1:0] ld_req_addr;
  logic                  ld_req_ready;
  logic                  ld_rsp_valid;
  logic [DATA_WIDTH-1:0] ld_rsp_data;
  logic                  ld_rsp_ready;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  ld_req_valid, ld_req_addr, ld_rsp_ready,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ld_req_ready, ld_rsp_valid, ld_rsp_data
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output ld_req_valid, ld_req_addr, ld_rsp_ready,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ld_req_ready, ld_rsp_valid, ld_rsp_data
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read ROM between a fetch and a
// load port; each port owns a one-entry response buffer (one cycle latency).
module rom_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_port_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd
);

  localparam int unsigned NPORT = 2;
  localparam int unsigned P_IF  = 0;
  localparam int unsigned P_LD  = 1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Pointer value 0 favours the fetch port on contention.
  localparam logic PTR_IF = 1'b0;
  localparam logic PTR_LD = 1'b1;

  buf_state_e            buf_q  [NPORT];
  buf_state_e            buf_d  [NPORT];
  logic [DATA_WIDTH-1:0] data_q [NPORT];
  logic [DATA_WIDTH-1:0] data_d [NPORT];
  logic                  ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

  logic [NPORT-1:0]      req_valid;
  logic [NPORT-1:0]      rsp_ready;
  logic [NPORT-1:0]      elig;
  logic [NPORT-1:0]      grant;

  assign req_valid = {bus.ld_req_valid, bus.if_req_valid};
  assign rsp_ready = {bus.ld_rsp_ready, bus.if_rsp_ready};

  // Eligibility is gated by rst_n so no request is accepted while in reset.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      elig[i] = rst_n && req_valid[i] && ((buf_q[i] == BUF_EMPTY) || rsp_ready[i]);
    end
  end

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    unique case (elig)
      2'b11:   grant = (ptr_q == PTR_LD) ? 2'b10 : 2'b01;
      default: grant = elig;
    endcase
    if (grant[P_IF]) begin
      ptr_d = PTR_LD;
    end else if (grant[P_LD]) begin
      ptr_d = PTR_IF;
    end
  end

  // ROM address follows the winner, otherwise holds the last granted address.
  always_comb begin
    rom_addr = last_addr_q;
    if (grant[P_LD]) begin
      rom_addr = bus.ld_req_addr;
    end else if (grant[P_IF]) begin
      rom_addr = bus.if_req_addr;
    end
    last_addr_d = rom_addr;
  end

  // Per-port buffer FSM: a grant always (re)loads, a consume without grant empties.
  always_comb begin
    for (int i = 0; i < int'(NPORT); i++) begin
      buf_d[i]  = buf_q[i];
      data_d[i] = data_q[i];
      unique case (buf_q[i])
        BUF_EMPTY: begin
          if (grant[i]) begin
            buf_d[i]  = BUF_FULL;
            data_d[i] = rom_rd;
          end
        end
        BUF_FULL: begin
          if (grant[i]) begin
            buf_d[i]  = BUF_FULL;
            data_d[i] = rom_rd;
          end else if (rsp_ready[i]) begin
            buf_d[i] = BUF_EMPTY;
          end
        end
        default: begin
          buf_d[i] = BUF_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NPORT); i++) begin
        buf_q[i]  <= BUF_EMPTY;
        data_q[i] <= '0;
      end
      ptr_q       <= PTR_IF;
      last_addr_q <= '0;
    end else begin
      for (int i = 0; i < int'(NPORT); i++) begin
        buf_q[i]  <= buf_d[i];
        data_q[i] <= data_d[i];
      end
      ptr_q       <= ptr_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign bus.if_req_ready = grant[P_IF];
  assign bus.ld_req_ready = grant[P_LD];
  assign bus.if_rsp_valid = (buf_q[P_IF] == BUF_FULL);
  assign bus.ld_rsp_valid = (buf_q[P_LD] == BUF_FULL);
  assign bus.if_rsp_data  = data_q[P_IF];
  assign bus.ld_rsp_data  = data_q[P_LD];

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios plus a random
// phase, with a per-port scoreboard of expected ROM words.
module tb_rom_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rd;

  always #5 clk = ~clk;

  rom_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rom_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd)
  );

  // ROM contents: distinct, non-zero word for every address.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {~a[5:0], a, 6'h2B, a};
  endfunction

  assign rom_rd = rom_word(rom_addr);

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q_if[$];
  logic [DW-1:0] q_ld[$];
  logic          hold_if = 1'b0, hold_ld = 1'b0;
  logic [DW-1:0] held_if, held_ld, sb_exp;

  // Scoreboard: push on accepted request, pop on consumed response.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_if.delete();
      q_ld.delete();
      hold_if = 1'b0;
      hold_ld = 1'b0;
    end else begin
      if (hold_if) begin
        n_cmp++;
        if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== held_if) begin
          n_err++;
          $display("FAIL if_hold: valid=%b data=%h, required valid=1 data=%h", bus.if_rsp_valid, bus.if_rsp_data, held_if);
        end
      end
      if (hold_ld) begin
        n_cmp++;
        if (bus.ld_rsp_valid !== 1'b1 || bus.ld_rsp_data !== held_ld) begin
          n_err++;
          $display("FAIL ld_hold: valid=%b data=%h, required valid=1 data=%h", bus.ld_rsp_valid, bus.ld_rsp_data, held_ld);
        end
      end
      if (bus.if_rsp_valid && bus.if_rsp_ready) begin
        n_cmp++;
        if (q_if.size() == 0) begin
          n_err++;
          $display("FAIL if_sb: data=%h, required no response outstanding", bus.if_rsp_data);
        end else begin
          sb_exp = q_if.pop_front();
          if (bus.if_rsp_data !== sb_exp) begin
            n_err++;
            $display("FAIL if_sb: data=%h, required %h", bus.if_rsp_data, sb_exp);
          end
        end
      end
      if (bus.ld_rsp_valid && bus.ld_rsp_ready) begin
        n_cmp++;
        if (q_ld.size() == 0) begin
          n_err++;
          $display("FAIL ld_sb: data=%h, required no response outstanding", bus.ld_rsp_data);
        end else begin
          sb_exp = q_ld.pop_front();
          if (bus.ld_rsp_data !== sb_exp) begin
            n_err++;
            $display("FAIL ld_sb: data=%h, required %h", bus.ld_rsp_data, sb_exp);
          end
        end
      end
      if (bus.if_req_valid && bus.if_req_ready) q_if.push_back(rom_word(bus.if_req_addr));
      if (bus.ld_req_valid && bus.ld_req_ready) q_ld.push_back(rom_word(bus.ld_req_addr));
      hold_if = bus.if_rsp_valid && !bus.if_rsp_ready;
      hold_ld = bus.ld_rsp_valid && !bus.ld_rsp_ready;
      held_if = bus.if_rsp_data;
      held_ld = bus.ld_rsp_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid = 1'b0; bus.if_req_addr = '0; bus.if_rsp_ready = 1'b0;
    bus.ld_req_valid = 1'b0; bus.ld_req_addr = '0; bus.ld_rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 10'h055; bus.if_rsp_ready = 1'b1;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 10'h0AA; bus.ld_rsp_ready = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (bus.if_req_ready !== 1'b0 || bus.ld_req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: if=%b ld=%b, required 0 0", bus.if_req_ready, bus.ld_req_ready);
    end
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b0 || bus.ld_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: if=%b ld=%b, required 0 0", bus.if_rsp_valid, bus.ld_rsp_valid);
    end
    n_cmp++;
    if (bus.if_rsp_data !== '0 || bus.ld_rsp_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: if=%h ld=%h, required 0 0", bus.if_rsp_data, bus.ld_rsp_data);
    end
    n_cmp++;
    if (rom_addr !== '0) begin
      n_err++;
      $display("FAIL reset_rom_addr: %h, required 0", rom_addr);
    end
    idle_inputs();
  endtask

  // Fetch stream starting in the first cycle after reset release.
  task automatic test_fetch_stream();
    rst_n = 1'b1;
    bus.if_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = AW'(i);
      #1;
      n_cmp++;
      if (bus.if_req_ready !== 1'b1 || rom_addr !== AW'(i)) begin
        n_err++;
        $display("FAIL fs_grant[%0d]: ready=%b rom_addr=%h, required 1 %h", i, bus.if_req_ready, rom_addr, AW'(i));
      end
      if (i > 0) begin
        n_cmp++;
        if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== rom_word(AW'(i - 1))) begin
          n_err++;
          $display("FAIL fs_rsp[%0d]: valid=%b data=%h, required 1 %h", i, bus.if_rsp_valid, bus.if_rsp_data, rom_word(AW'(i - 1)));
        end
      end
      tick();
    end
    bus.if_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== rom_word(10'h003)) begin
      n_err++;
      $display("FAIL fs_last: valid=%b data=%h, required 1 %h", bus.if_rsp_valid, bus.if_rsp_data, rom_word(10'h003));
    end
    tick();
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fs_drain: valid=%b, required 0", bus.if_rsp_valid);
    end
  endtask

  task automatic test_alternate();
    logic exp_if;
    do_reset();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 10'h010; bus.if_rsp_ready = 1'b1;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 10'h200; bus.ld_rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_if = (k % 2 == 0);
      n_cmp++;
      if (bus.if_req_ready !== exp_if || bus.ld_req_ready !== !exp_if
          || rom_addr !== (exp_if ? 10'h010 : 10'h200)) begin
        n_err++;
        $display("FAIL alt_grant[%0d]: if=%b ld=%b rom_addr=%h, required if=%b ld=%b", k, bus.if_req_ready, bus.ld_req_ready, rom_addr, exp_if, !exp_if);
      end
      n_cmp++;
      if (bus.if_rsp_valid !== (k % 2 == 1) || bus.ld_rsp_valid !== (k > 0 && k % 2 == 0)) begin
        n_err++;
        $display("FAIL alt_rsp[%0d]: if_valid=%b ld_valid=%b, required %b %b", k, bus.if_rsp_valid, bus.ld_rsp_valid, (k % 2 == 1), (k > 0 && k % 2 == 0));
      end
      tick();
    end
    bus.if_req_valid = 1'b0;
    bus.ld_req_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_hold();
    do_reset();
    bus.ld_rsp_ready = 1'b1;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 10'h011; bus.if_rsp_ready = 1'b0;
    tick();
    bus.if_req_addr  = 10'h012;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 10'h3FF;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (bus.if_req_ready !== 1'b0 || bus.ld_req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL hold_grant[%0d]: if=%b ld=%b, required 0 1", k, bus.if_req_ready, bus.ld_req_ready);
      end
      n_cmp++;
      if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== rom_word(10'h011)) begin
        n_err++;
        $display("FAIL hold_if_data[%0d]: valid=%b data=%h, required 1 %h", k, bus.if_rsp_valid, bus.if_rsp_data, rom_word(10'h011));
      end
      if (k > 0) begin
        n_cmp++;
        if (bus.ld_rsp_valid !== 1'b1 || bus.ld_rsp_data !== rom_word(10'h3FF)) begin
          n_err++;
          $display("FAIL hold_ld_data[%0d]: valid=%b data=%h, required 1 %h", k, bus.ld_rsp_valid, bus.ld_rsp_data, rom_word(10'h3FF));
        end
      end
      tick();
    end
    bus.if_req_valid = 1'b0;
    bus.ld_req_valid = 1'b0;
    bus.if_rsp_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reload();
    do_reset();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 10'h004; bus.if_rsp_ready = 1'b0;
    tick();
    bus.if_req_addr  = 10'h005;
    bus.if_rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.if_req_ready !== 1'b1 || bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== rom_word(10'h004)) begin
      n_err++;
      $display("FAIL reload_same_cycle: ready=%b valid=%b data=%h, required 1 1 %h", bus.if_req_ready, bus.if_rsp_valid, bus.if_rsp_data, rom_word(10'h004));
    end
    tick();
    bus.if_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== rom_word(10'h005)) begin
      n_err++;
      $display("FAIL reload_next: valid=%b data=%h, required 1 %h", bus.if_rsp_valid, bus.if_rsp_data, rom_word(10'h005));
    end
    tick();
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reload_drain: valid=%b, required 0", bus.if_rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 10'h020; bus.if_rsp_ready = 1'b0;
    tick();
    bus.if_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pending: valid=%b, required 1", bus.if_rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b0 || bus.if_rsp_data !== '0) begin
      n_err++;
      $display("FAIL rmid_async: valid=%b data=%h, required 0 0", bus.if_rsp_valid, bus.if_rsp_data);
    end
    tick();
    rst_n = 1'b1;
    bus.if_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (bus.if_rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_stale[%0d]: valid=%b data=%h, required valid 0", k, bus.if_rsp_valid, bus.if_rsp_data);
      end
    end
    bus.if_req_valid = 1'b1; bus.if_req_addr = 10'h021;
    tick();
    bus.if_req_valid = 1'b0;
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== rom_word(10'h021)) begin
      n_err++;
      $display("FAIL rmid_after: valid=%b data=%h, required 1 %h", bus.if_rsp_valid, bus.if_rsp_data, rom_word(10'h021));
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.if_rsp_ready = 1'b1;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 10'h3FF;
    tick();
    bus.if_req_addr = 10'h000;
    #1;
    n_cmp++;
    if (bus.if_req_ready !== 1'b1 || bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== rom_word(10'h3FF)) begin
      n_err++;
      $display("FAIL wrap_first: ready=%b valid=%b data=%h, required 1 1 %h", bus.if_req_ready, bus.if_rsp_valid, bus.if_rsp_data, rom_word(10'h3FF));
    end
    tick();
    bus.if_req_valid = 1'b0;
    n_cmp++;
    if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== rom_word(10'h000)) begin
      n_err++;
      $display("FAIL wrap_second: valid=%b data=%h, required 1 %h", bus.if_rsp_valid, bus.if_rsp_data, rom_word(10'h000));
    end
    tick();
  endtask

  task automatic test_random();
    logic          ptr_m;
    logic [AW-1:0] last_m;
    logic          e_if, e_ld, g_if, g_ld;
    logic [AW-1:0] exp_addr;
    do_reset();
    ptr_m  = 1'b0;
    last_m = '0;
    for (int c = 0; c < 300; c++) begin
      bus.if_req_valid = ($urandom_range(0, 3) != 0);
      bus.ld_req_valid = ($urandom_range(0, 3) != 0);
      bus.if_req_addr  = AW'($urandom_range(0, 1023));
      bus.ld_req_addr  = AW'($urandom_range(0, 1023));
      bus.if_rsp_ready = ($urandom_range(0, 2) != 0);
      bus.ld_rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      e_if = bus.if_req_valid && (!bus.if_rsp_valid || bus.if_rsp_ready);
      e_ld = bus.ld_req_valid && (!bus.ld_rsp_valid || bus.ld_rsp_ready);
      g_if = e_if && (!e_ld || !ptr_m);
      g_ld = e_ld && (!e_if || ptr_m);
      exp_addr = g_ld ? bus.ld_req_addr : (g_if ? bus.if_req_addr : last_m);
      n_cmp++;
      if (bus.if_req_ready !== g_if || bus.ld_req_ready !== g_ld || rom_addr !== exp_addr) begin
        n_err++;
        $display("FAIL rnd_grant[%0d]: if=%b ld=%b rom_addr=%h, required %b %b %h", c, bus.if_req_ready, bus.ld_req_ready, rom_addr, g_if, g_ld, exp_addr);
      end
      if (g_if) ptr_m = 1'b1;
      else if (g_ld) ptr_m = 1'b0;
      last_m = exp_addr;
      tick();
    end
    bus.if_req_valid = 1'b0;
    bus.ld_req_valid = 1'b0;
    bus.if_rsp_ready = 1'b1;
    bus.ld_rsp_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (q_if.size() != 0 || q_ld.size() != 0) begin
      n_err++;
      $display("FAIL rnd_drain: outstanding if=%0d ld=%0d, required 0 0", q_if.size(), q_ld.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_stream();
    test_alternate();
    test_hold();
    test_reload();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, ROM word width in bits, SHALL be provided.
REQ-002 Parameter ADDR_WIDTH, default 10, ROM word-address width in bits, SHALL be provided.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 if_req_valid  input  1  instruction-fetch port request.
REQ-006 if_req_addr  input  ADDR_WIDTH  fetch word address.
REQ-007 if_req_ready  output  1  fetch request accepted this cycle.
REQ-008 if_rsp_valid  output  1  fetch response data valid.
REQ-009 if_rsp_data  output  DATA_WIDTH  fetch response word.
REQ-010 if_rsp_ready  input  1  fetch side consumes response.
REQ-011 ld_req_valid / ld_req_addr / ld_req_ready / ld_rsp_valid / ld_rsp_data / ld_rsp_ready SHALL mirror REQ-005..010 for the load-data port.
REQ-012 rom_addr  output  ADDR_WIDTH  address to the single-port ROM A input.
REQ-013 rom_rd  input  DATA_WIDTH  combinational ROM read data for rom_addr.

Function
REQ-014 Each port SHALL own a one-entry response buffer with state EMPTY or FULL.
REQ-015 A port SHALL be eligible when req_valid=1 and its buffer is EMPTY, or FULL with rsp_ready=1 this cycle.
REQ-016 At most one port SHALL be granted per cycle; req_ready SHALL be high only for the granted port.
REQ-017 Arbitration SHALL be round-robin: on contention the port not granted most recently wins; a single eligible port SHALL win unconditionally.
REQ-018 rom_addr SHALL be combinationally muxed from the granted port's req_addr; with no grant it SHALL hold the last granted address.
REQ-019 On a grant in cycle N, rom_rd SHALL be captured into that port's buffer at the edge ending cycle N; rsp_valid=1 from cycle N+1 (latency one cycle).
REQ-020 rsp_valid SHALL equal buffer FULL; rsp_data SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-021 rsp_valid and rsp_ready both high SHALL empty the buffer, unless the same port is granted that cycle, in which case the buffer reloads and stays FULL (back-to-back, one word per cycle).
REQ-022 A port with a FULL buffer and rsp_ready=0 SHALL NOT be granted; the other port SHALL proceed unaffected.
REQ-023 req_ready SHALL be combinational from req_valid, buffer state, rsp_ready and the priority pointer; no combinational path from rom_rd to any output except via registers.
REQ-024 Priority pointer SHALL update only on a grant, to point to the non-granted port.
REQ-025 Requests with req_valid=0 SHALL never change any state.

Reset
REQ-026 While rst_n=0: both buffers EMPTY, if_rsp_valid=ld_rsp_valid=0, rsp_data=0, rom_addr=0, priority pointer favours the fetch port, both req_ready=0.
REQ-027 Reset assertion mid-transaction SHALL discard buffered data immediately; first grant possible in the first cycle with rst_n=1.

Verification
REQ-028 Reset release, fetch only, addrs 0x000..0x003 back-to-back, if_rsp_ready=1 -> if_req_ready=1 every cycle, rom words 0..3 on if_rsp_data cycles N+1..N+4.
REQ-029 Both ports valid every cycle, fetch 0x010, load 0x200, both rsp_ready=1 -> grants alternate IF, LD, IF, LD starting with IF; each port one response per two cycles.
REQ-030 Fetch response held with if_rsp_ready=0 for 5 cycles while load issues 0x3FF -> if_rsp_data constant, if_req_ready=0, ld port served every cycle with rom[0x3FF].
REQ-031 Fetch buffer FULL, if_rsp_ready=1 and new fetch 0x005 same cycle -> if_req_ready=1, if_rsp_valid stays 1, next word rom[0x005].
REQ-032 rst_n pulled low one cycle after grant of 0x020 with response pending -> rsp_valid=0 immediately, no stale rom[0x020] after release.
REQ-033 Address wrap: fetch 0x3FF then 0x000 -> rom[0x3FF] then rom[0x000], no extra latency.
